// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state type and constants for the hazard controller
package pipeline_hazard_controller_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int SRAM_LATENCY_DEF = 6;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: pipeline status inputs and stall/flush/perf outputs of the controller
interface pipeline_hazard_controller_if #(parameter int PERF_W = 16);
    logic              forward_en;
    logic [4:0]        id_src1;
    logic [4:0]        id_src2;
    logic              id_two_src;
    logic [4:0]        exe_dest;
    logic              exe_wb_en;
    logic              exe_mem_read;
    logic [4:0]        mem_dest;
    logic              mem_wb_en;
    logic              exe_branch_taken;
    logic              mem_access;
    logic              hazard_freeze;
    logic              pipe_stall;
    logic              flush;
    logic [PERF_W-1:0] stall_cycles;
    logic [7:0]        flush_count;
    modport master (
        output forward_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, exe_branch_taken, mem_access,
        input  hazard_freeze, pipe_stall, flush, stall_cycles, flush_count
    );
    modport slave (
        input  forward_en, id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_read,
               mem_dest, mem_wb_en, exe_branch_taken, mem_access,
        output hazard_freeze, pipe_stall, flush, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_compare.sv
// hazard_compare: RAW hazard detect of ID sources against EXE/MEM destinations
module hazard_compare
    import pipeline_hazard_controller_pkg::*;
(
    input  logic       forward_en_i,
    input  logic [4:0] src1_i,
    input  logic [4:0] src2_i,
    input  logic       two_src_i,
    input  logic [4:0] exe_dest_i,
    input  logic       exe_wb_en_i,
    input  logic       exe_mem_read_i,
    input  logic [4:0] mem_dest_i,
    input  logic       mem_wb_en_i,
    output logic       match_o
);
    function automatic logic hit(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic two);
        return (d != REG_ZERO) && ((d == s1) || (two && (d == s2)));
    endfunction
    logic exe_hit, mem_hit;
    assign exe_hit = hit(exe_dest_i, src1_i, src2_i, two_src_i);
    assign mem_hit = hit(mem_dest_i, src1_i, src2_i, two_src_i);
    // with forwarding only a load in EXE cannot be bypassed in time
    assign match_o = forward_en_i ? (exe_mem_read_i && exe_hit)
                                  : ((exe_wb_en_i && exe_hit) || (mem_wb_en_i && mem_hit));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencing with SRAM wait FSM and saturating perf counters
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int SRAM_LATENCY = SRAM_LATENCY_DEF,
    parameter int CNT_W        = 4,
    parameter int PERF_W       = 16
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_hazard_controller_if.slave  hz
);
    localparam bit             MULTI    = SRAM_LATENCY > 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULTI ? SRAM_LATENCY - 2 : 0);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]        flush_cnt_q, flush_cnt_d;
    logic              match_hz, start, stall, freeze, flush_c;
    hazard_compare u_cmp (
        .forward_en_i  (hz.forward_en),
        .src1_i        (hz.id_src1),
        .src2_i        (hz.id_src2),
        .two_src_i     (hz.id_two_src),
        .exe_dest_i    (hz.exe_dest),
        .exe_wb_en_i   (hz.exe_wb_en),
        .exe_mem_read_i(hz.exe_mem_read),
        .mem_dest_i    (hz.mem_dest),
        .mem_wb_en_i   (hz.mem_wb_en),
        .match_o       (match_hz)
    );
    always_comb begin
        start       = MULTI && hz.mem_access && (state_q == IDLE);
        stall       = start || ((state_q == WAIT) && (cnt_q != '0));
        state_d     = start ? WAIT : ((state_q == WAIT) && (cnt_q == '0)) ? IDLE : state_q;
        cnt_d       = start ? CNT_INIT : stall ? cnt_q - CNT_W'(1) : cnt_q;
        // a stalled branch stays in EXE and flushes on the release cycle
        flush_c     = !stall && hz.exe_branch_taken;
        freeze      = !stall && !hz.exe_branch_taken && match_hz;
        stall_cnt_d = ((freeze || stall) && !(&stall_cnt_q)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_c && !(&flush_cnt_q)) ? flush_cnt_q + 8'd1 : flush_cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign hz.pipe_stall    = stall && !rst;
    assign hz.hazard_freeze = freeze && !rst;
    assign hz.flush         = flush_c && !rst;
    assign hz.stall_cycles  = stall_cnt_q;
    assign hz.flush_count   = flush_cnt_q;
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline with forwarding.
- Watches the ID-stage source registers (src1, src2, is_two_source) against the EXE and MEM destinations.
- Watches the EXE branch outcome and MEM-stage SRAM accesses.
- Drives the ID Freeze (bubble insert), a global pipeline hold for multi-cycle SRAM accesses, and the IF/ID flush.
- Keeps saturating performance counters.

Parameters:
- SRAM_LATENCY, 6, total cycles per SRAM access (legal 1..16).
- CNT_W, 4, width of the SRAM wait counter.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- forward_en  input  1  forwarding unit enabled.
- id_src1  input  5  ID instruction source 1.
- id_src2  input  5  ID instruction source 2 (0 when immediate).
- id_two_src  input  1  ID instruction reads src2.
- exe_dest  input  5  EXE-stage destination register.
- exe_wb_en  input  1  EXE-stage writeback enable.
- exe_mem_read  input  1  EXE-stage instruction is a load.
- mem_dest  input  5  MEM-stage destination register.
- mem_wb_en  input  1  MEM-stage writeback enable.
- exe_branch_taken  input  1  branch resolved taken in EXE.
- mem_access  input  1  MEM-stage instruction is a load or store.
- hazard_freeze  output  1  hold PC and IF/ID; zero ID control signals.
- pipe_stall  output  1  hold every pipeline register (SRAM wait).
- flush  output  1  clear IF/ID.
- stall_cycles  output  PERF_W  saturating count of cycles with hazard_freeze or pipe_stall high.
- flush_count  output  8  saturating count of flush cycles.

Behaviour:

Reset:
- While rst is high, all outputs are 0, the FSM is in IDLE, and all counters are 0.
- Reset asserted mid-wait aborts the wait immediately (asynchronous).

Raw hazard, combinational (match_hz):
- Register 0 never matches.
- src2 is compared only when id_two_src = 1.
- forward_en = 0: hazard when exe_wb_en && exe_dest matches a source, or mem_wb_en && mem_dest matches a source.
- forward_en = 1: hazard only on load-use, i.e. exe_mem_read && exe_dest matches a source.

SRAM FSM, states IDLE and WAIT; cnt is CNT_W bits:
- IDLE, mem_access = 1, SRAM_LATENCY > 1: pipe_stall = 1 in the same cycle (Mealy); cnt <= SRAM_LATENCY-2; next state WAIT.
- IDLE, SRAM_LATENCY = 1: never stalls; the FSM stays in IDLE.
- WAIT, cnt != 0: pipe_stall = 1; cnt decrements.
- WAIT, cnt = 0: pipe_stall = 0 (release cycle, pipeline advances); next state IDLE.
- Total stall per access is SRAM_LATENCY-1 cycles. With the release cycle, the access completes in SRAM_LATENCY cycles.
- mem_access high in the cycle after release is a new access and retriggers the FSM.
- mem_access dropping in WAIT does not abort the wait; the count runs to completion.

Output priority, all outputs combinational from state and inputs:
- pipe_stall = 1: hazard_freeze = 0 and flush = 0. A branch held in EXE flushes when released.
- else exe_branch_taken = 1: flush = 1 and hazard_freeze = 0. The squashed ID instruction needs no bubble.
- else: hazard_freeze = match_hz.

Counters, updated on the rising clock edge:
- stall_cycles increments when (hazard_freeze | pipe_stall) and holds at all-ones.
- flush_count increments when flush = 1 and holds at 255.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WAIT);
  - the REG_ZERO constant (5'd0);
  - the SRAM_LATENCY default, shared with the SRAM controller.
- One combinational sub-module, hazard_compare, computes match_hz from the source, destination and enable signals plus forward_en.
- FSM, priority logic and counters live in the top module.

Test Plan:
1. Load-use with forwarding: forward_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src1=5 -> hazard_freeze=1 for exactly that cycle; with exe_mem_read=0 -> hazard_freeze=0.
2. Non-forwarding: forward_en=0, mem_wb_en=1, mem_dest=7, id_src2=7 -> hazard_freeze=1 when id_two_src=1 and 0 when id_two_src=0. id_src1=0 with exe_dest=0 -> never freezes.
3. SRAM wait: SRAM_LATENCY=6, mem_access pulse held -> pipe_stall high for exactly 5 consecutive cycles, then low for 1 cycle. Back-to-back mem_access -> new 5-cycle stall starts on the following cycle.
4. Branch during SRAM wait: exe_branch_taken=1 held through the stall -> flush=0 while pipe_stall=1, flush=1 in the release cycle. Branch together with a load-use hazard -> flush=1, hazard_freeze=0.
5. Reset mid-WAIT: assert rst 3 cycles into a stall -> all outputs 0 asynchronously, counters 0. After deassert with mem_access=0 -> FSM in IDLE, pipe_stall=0.
6. Saturation: force 70000 hazard cycles -> stall_cycles=16'hFFFF. Force 300 flush cycles -> flush_count=255.
